serial_subtractor: RTL
======================

// Module: serial_subtractor
//
// PURPOSE
// Bit-serial WIDTH-bit subtractor built around the existing full_subtractor cell.
// - Loads operands a and b on a start request.
// - Produces a-b, one bit per clock, LSB first, through a single full_subtractor plus a borrow flip-flop.
// - Returns the full difference and the final borrow with a one-cycle done pulse.
// - Sits directly downstream of operand producers, as the sequential consumer of the full_subtractor cell.
//
// PARAMETERS
// WIDTH  8  operand/result width in bits (>=2)
//
// PORTS
// clk    in   1      rising-edge clock
// rst_n  in   1      asynchronous active-low reset
// start  in   1      request; sampled only while idle (busy=0)
// a      in   WIDTH  minuend, captured on the accepted start edge
// b      in   WIDTH  subtrahend, captured on the accepted start edge
// busy   out  1      high while a subtraction is in progress
// done   out  1      one-cycle pulse: diff/bout valid
// diff   out  WIDTH  a-b modulo 2^WIDTH; held until next completion
// bout   out  1      final borrow (1 iff a<b unsigned); held with diff
//
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE; busy=0, done=0, diff=0, bout=0.
//   Operand shift registers, result shift register, borrow FF and bit counter all clear.
// - FSM has two states: IDLE and SHIFT.
// - IDLE & start (edge E0):
//   - load sh_a<=a, sh_b<=b, brw<=0, cnt<=0, busy<=1, state<=SHIFT.
//   - done<=0; diff and bout keep their old values.
// - IDLE & !start: hold all state; done<=0.
// - SHIFT, every edge:
//   - full_subtractor inputs: (sh_a[0], sh_b[0], brw).
//   - brw<=bor.
//   - shift result register right, inserting the diff bit at its MSB.
//   - shift sh_a and sh_b right by 1; cnt<=cnt+1.
// - Completion: the SHIFT edge with cnt==WIDTH-1 is edge E_WIDTH. On that edge:
//   - diff<=completed result (including this edge's bit), bout<=bor.
//   - done<=1, busy<=0, state<=IDLE.
// - Latency: done and the final diff/bout are visible after edge E0+WIDTH.
// - Throughput: one operation per WIDTH+1 cycles (start accepted in the cycle done is high).
// - start while busy: ignored; no queueing, the current operation is unaffected.
// - a and b are sampled only at E0; later changes have no effect.
// - Counter width is $clog2(WIDTH). It must reach exactly WIDTH-1 and must not wrap.
// - Reset mid-operation: abort immediately; all outputs return to reset values and no done pulse is issued.
// - done is never high in the same cycle as busy.
//
// STRUCTURE
// - Shared include file sub_defs.vh: state encoding localparams
//   (ST_IDLE=1'b0, ST_SHIFT=1'b1) and the default WIDTH.
// - One sub-module instance: full_subtractor u_fs(a,b,c,diff,bor), the existing gate-level cell, used unchanged.
// - Everything else in this module: FSM, counter, three shift registers, borrow FF, output registers.
//
// TESTING
// - Tests use WIDTH=8, clk period 10, and $monitor/$dumpvars on all ports.
// 1 Basic: a=100, b=37, start 1 cycle -> busy 8 cycles; done after edge E8; diff=63, bout=0.
// 2 Negative: a=37, b=100 -> diff=193 (8'hC1), bout=1.
// 3 Edges:
//   - 0-0 -> diff=0, bout=0.
//   - 0-1 -> diff=255, bout=1.
//   - 255-255 -> diff=0, bout=0.
//   - 128-127 -> diff=1, bout=0.
// 4 Busy protection:
//   - a=200, b=55 start.
//   - At E3 pulse start with a=1, b=1 and change a, b -> result still diff=145, bout=0; exactly one done pulse.
// 5 Back-to-back:
//   - hold start=1 continuously with a=10, b=3, then a=3, b=10 presented in the done cycle.
//   - -> done at E8 (diff=7, bout=0) and at E17 (diff=249, bout=1).
// 6 Reset: rst_n=0 at E4 of a=9-4 run -> busy, done, diff, bout =0 immediately.
//   After release, a new start 9-4 -> diff=5, bout=0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: default width and FSM state encoding.
package serial_subtractor_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// Gate-level full subtractor cell: diff = a - b - c, bor set when the result underflows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic bor
);

  logic axb;

  assign axb  = a ^ b;
  assign diff = axb ^ c;
  // Borrow out when b exceeds a, or they are equal and a borrow comes in.
  assign bor  = (~a & b) | (~axb & c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, through one full_subtractor and a borrow flip-flop.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   sh_a_q;
  logic [WIDTH-1:0]   sh_b_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   res_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               brw_q;
  logic               fs_diff;
  logic               fs_bor;

  full_subtractor u_fs (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .c    (brw_q),
    .diff (fs_diff),
    .bor  (fs_bor)
  );

  // Result fills from the MSB end so the last bit lands it fully aligned.
  assign res_d = {fs_diff, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sh_a_q  <= a;
            sh_b_q  <= b;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          brw_q  <= fs_bor;
          res_q  <= res_d;
          sh_a_q <= {1'b0, sh_a_q[WIDTH-1:1]};
          sh_b_q <= {1'b0, sh_b_q[WIDTH-1:1]};
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            // Counter parks at zero rather than relying on natural wrap.
            cnt_q   <= '0;
            diff    <= res_d;
            bout    <= fs_bor;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
